uart_rx_loader: RTL and testbench
=================================

Name: uart_rx_loader

Overview:
- Serial receive front end for the pipelined MIPS core. Consumes the top-level `rx` pin.
- Recovers 8N1 UART bytes using 16x oversampling.
- Assembles each group of four bytes into a little-endian 32-bit word for the program/data loader.
- Sits upstream of the datapath's memory-loading path; the datapath itself only ever sees whole bytes or whole words.

Parameters:
- TICK_DIV, 163: clock cycles per oversample tick (50 MHz / (19200*16)). Legal range ≥ 2.
- DATA_BITS, 8: data bits per frame. Fixed to 8 for word assembly.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- rx  in  1  raw serial line, asynchronous to clk, idle high.
- word_clear  in  1  synchronous pulse; discards any partial word and sets the byte index to 0.
- byte_out  out  8  last good received byte.
- byte_valid  out  1  one-cycle pulse when byte_out is updated.
- word_out  out  32  last assembled word; first received byte is in [7:0].
- word_valid  out  1  one-cycle pulse when word_out is updated.
- frame_err  out  1  one-cycle pulse when the stop bit is sampled low.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (reset=0, async):
  - byte_out=0, word_out=0, byte_valid=0, word_valid=0, frame_err=0, busy=0.
  - Byte index=0, FSM=IDLE, armed=1, both synchronizer flops=1.
- rx passes through a 2-flop synchronizer; all decisions use the synchronized value rxs.
- Tick prescaler:
  - Free-running counter 0..TICK_DIV-1.
  - tick=1 for one clk when the counter equals TICK_DIV-1.
  - Not reset by the FSM.
- FSM states: IDLE, START, DATA, STOP. A 4-bit sample counter sc advances on tick only.
- IDLE:
  - If rxs=1, set armed=1.
  - If rxs=0 and armed=1, go to START with sc=0.
- START:
  - At the tick where sc=7 (mid start bit), sample rxs.
  - rxs=0: go to DATA with sc=0 and bit index=0.
  - rxs=1: false start; go to IDLE with no output pulses.
- DATA:
  - At each tick where sc=15, shift rxs in LSB first and increment the bit index.
  - After bit 7 is sampled, go to STOP with sc=0.
- STOP: at the tick where sc=15, sample rxs.
  - rxs=1: on the next clk edge, byte_out is updated and byte_valid=1 for exactly 1 cycle. Go to IDLE.
  - rxs=0: frame_err=1 for 1 cycle. The byte is discarded, byte_out is unchanged and the byte index is unchanged. armed=0 and go to IDLE. This prevents a held-low line (break) from re-triggering until rxs is seen high.
- Frame duration: 10 bits × 16 ticks × TICK_DIV clk. Byte latency from the stop-bit midpoint is 1 clk.
- Word assembly (2-bit byte index idx):
  - On each byte_valid, the byte is written to lane idx and idx increments, wrapping 3→0.
  - When idx=3 before the increment, word_out is updated with all four lanes. word_valid is asserted in the same cycle as that byte_valid.
- word_clear:
  - Forces idx=0 and discards the partial word.
  - If it coincides with an accepted byte, the clear applies first: that byte is stored as lane 0 and idx becomes 1.
  - word_clear never affects the serial FSM.
- byte_valid, word_valid and frame_err are registered. byte_valid and frame_err are mutually exclusive. None of the three is ever high for more than 1 cycle.
- Reset mid-frame aborts the frame; no pulse is produced.

Decomposition:
- Shared package uart_pkg holds:
  - The FSM state enum (IDLE/START/DATA/STOP).
  - OVERSAMPLE=16, MID_START=7, MID_BIT=15.
- One sub-module, baud_tick_gen: parameter TICK_DIV, ports clk/reset/tick, counter width $clog2(TICK_DIV).
- The synchronizer, FSM and word assembler stay in uart_rx_loader.

Test Plan (TICK_DIV=4, so 64 clk per bit):
- Reset: hold reset=0 with rx toggling → all outputs 0. Release and keep rx=1 for 2000 clk → no pulses, busy=0.
- Send 0xA5 with a good stop bit → byte_out=0xA5 and byte_valid high for 1 cycle; frame_err=0, word_valid=0, busy falls in the same cycle.
- Send 0x78,0x56,0x34,0x12 → word_out=0x12345678. word_valid pulses once, coincident with the 4th byte_valid only.
- Glitch: rx low for 20 clk (under half a bit) → no byte_valid and no frame_err; busy returns to 0.
- Send 0x3C with stop=0, then hold rx=0 for 300 clk → exactly one frame_err pulse, no byte_valid, idx unchanged. Then rx=1 for 64 clk and send 0x01 → byte_out=0x01.
- Send 0x11,0x22, then pulse word_clear, then send 0xDD,0xCC,0xBB,0xAA → word_out=0xAABBCCDD. Then assert reset mid-frame → outputs cleared; the next frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive front end.
// Holds the receiver FSM state type and the oversampling constants used to
// locate the middle of the start bit and of each subsequent bit.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned SC_W       = $clog2(OVERSAMPLE);

  // Sample-counter values at which the line is sampled.
  localparam logic [SC_W-1:0] MID_START = SC_W'(7);
  localparam logic [SC_W-1:0] MID_BIT   = SC_W'(15);

endpackage

// File: rtl/baud_tick_gen.sv
// Oversample tick prescaler.
// Free-running counter 0..TICK_DIV-1; tick is high for one clk whenever the
// counter holds TICK_DIV-1.
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous, active-low reset
//   tick  - one-cycle oversample strobe
module baud_tick_gen #(
  parameter int unsigned TICK_DIV = 163
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned     CW   = $clog2(TICK_DIV);
  localparam logic [CW-1:0]   LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_rx_loader.sv
// UART 8N1 receiver with 16x oversampling and little-endian word assembly.
// Ports:
//   clk        - system clock, rising edge
//   reset      - asynchronous, active-low reset
//   rx         - raw serial line (asynchronous, idle high)
//   word_clear - synchronous pulse: drop partial word, byte index -> 0
//   byte_out   - last good byte;   byte_valid - 1-cycle update pulse
//   word_out   - last full word (first byte in [7:0]); word_valid - pulse
//   frame_err  - 1-cycle pulse when the stop bit samples low
//   busy       - high whenever the receiver FSM is not idle
module uart_rx_loader
  import uart_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 163,
  parameter int unsigned DATA_BITS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  input  logic        word_clear,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  output logic [31:0] word_out,
  output logic        word_valid,
  output logic        frame_err,
  output logic        busy
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  logic            tick;
  logic            sync1_q, sync2_q, rxs;
  rx_state_e       state_q, state_d;
  logic [SC_W-1:0] sc_q, sc_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            armed_q, armed_d;
  logic [7:0]      byte_q, byte_d;
  logic            byte_valid_q, byte_valid_d;
  logic            frame_err_q, frame_err_d;
  logic [31:0]     word_q, word_d;
  logic            word_valid_q, word_valid_d;
  logic [1:0]      idx_q, idx_d;
  logic [23:0]     lanes_q, lanes_d;
  logic            accept;
  logic [1:0]      eff_idx;

  baud_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  assign rxs = sync2_q;

  always_comb begin
    state_d      = state_q;
    sc_d         = sc_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    armed_d      = armed_q;
    byte_d       = byte_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    word_d       = word_q;
    word_valid_d = 1'b0;
    idx_d        = idx_q;
    lanes_d      = lanes_q;
    accept       = 1'b0;

    case (state_q)
      IDLE: begin
        if (rxs) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d = START;
          sc_d    = '0;
        end
      end
      START: begin
        if (tick) begin
          if (sc_q == MID_START) begin
            if (!rxs) begin
              state_d = DATA;
              sc_d    = '0;
              bit_d   = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            sc_d = sc_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          sc_d = sc_q + 1'b1;
          if (sc_q == MID_BIT) begin
            shift_d = {rxs, shift_q[7:1]};
            bit_d   = bit_q + 1'b1;
            if (bit_q == LAST_BIT) begin
              state_d = STOP;
              sc_d    = '0;
            end
          end
        end
      end
      STOP: begin
        if (tick) begin
          sc_d = sc_q + 1'b1;
          if (sc_q == MID_BIT) begin
            state_d = IDLE;
            if (rxs) begin
              accept = 1'b1;
            end else begin
              // Break/held-low line must be seen high before re-arming.
              frame_err_d = 1'b1;
              armed_d     = 1'b0;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      byte_d       = shift_q;
      byte_valid_d = 1'b1;
    end

    // Clear takes effect before a coincident byte is placed.
    eff_idx = word_clear ? 2'd0 : idx_q;
    if (accept) begin
      case (eff_idx)
        2'd0:    lanes_d[7:0]   = shift_q;
        2'd1:    lanes_d[15:8]  = shift_q;
        2'd2:    lanes_d[23:16] = shift_q;
        default: begin
          word_d       = {shift_q, lanes_q};
          word_valid_d = 1'b1;
        end
      endcase
      idx_d = eff_idx + 2'd1;
    end else begin
      idx_d = eff_idx;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      state_q      <= IDLE;
      sc_q         <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      armed_q      <= 1'b1;
      byte_q       <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      idx_q        <= '0;
      lanes_q      <= '0;
    end else begin
      sync1_q      <= rx;
      sync2_q      <= sync1_q;
      state_q      <= state_d;
      sc_q         <= sc_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      armed_q      <= armed_d;
      byte_q       <= byte_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      idx_q        <= idx_d;
      lanes_q      <= lanes_d;
    end
  end

  assign byte_out   = byte_q;
  assign byte_valid = byte_valid_q;
  assign word_out   = word_q;
  assign word_valid = word_valid_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_loader.sv
// Testbench for uart_rx_loader with TICK_DIV=4 (64 clk per serial bit).
// A behavioural model (expected-byte queue plus a four-lane word array) is
// checked against the DUT on every negative clock edge; directed checks with
// literal values pin the model at the end of each scenario.
module tb_uart_rx_loader;

  localparam int unsigned TD      = 4;
  localparam int          BIT_CLK = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rx = 1'b1;
  logic        word_clear = 1'b0;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic [31:0] word_out;
  logic        word_valid;
  logic        frame_err;
  logic        busy;

  always #5 clk = ~clk;

  uart_rx_loader #(.TICK_DIV(TD), .DATA_BITS(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .word_clear (word_clear),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .word_out   (word_out),
    .word_valid (word_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]  exp_q[$];
  logic [7:0]  m_lane[4];
  int unsigned m_idx  = 0;
  logic [7:0]  m_byte = '0;
  logic [31:0] m_word = '0;
  int unsigned bv_cnt = 0, wv_cnt = 0, fe_cnt = 0;
  logic        clear_seen = 1'b0;
  logic        prev_bv = 1'b0, prev_wv = 1'b0, prev_fe = 1'b0;

  always @(negedge clk) begin
    logic        exp_wv;
    int unsigned eidx;
    exp_wv = 1'b0;
    if (!reset) begin
      check("reset_bytes", {16'h0, byte_out, 4'h0, busy, frame_err, word_valid, byte_valid}, 32'h0);
      check("reset_word", word_out, 32'h0);
      m_idx = 0; m_byte = '0; m_word = '0;
      exp_q.delete();
      clear_seen = 1'b0;
      prev_bv = 1'b0; prev_wv = 1'b0; prev_fe = 1'b0;
    end else begin
      if (byte_valid) begin
        bv_cnt++;
        check("busy_low_at_byte", 32'(busy), 32'h0);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_byte: got 0x%0h, expected no byte (t=%0t)", byte_out, $time);
        end else begin
          m_byte = exp_q.pop_front();
        end
        eidx = clear_seen ? 0 : m_idx;
        m_lane[eidx] = m_byte;
        if (eidx == 3) begin
          exp_wv = 1'b1;
          m_word = {m_lane[3], m_lane[2], m_lane[1], m_lane[0]};
        end
        m_idx = (eidx + 1) % 4;
      end else if (clear_seen) begin
        m_idx = 0;
      end
      if (word_valid) wv_cnt++;
      if (frame_err)  fe_cnt++;
      check("byte_out", 32'(byte_out), 32'(m_byte));
      check("word_valid", 32'(word_valid), 32'(exp_wv));
      check("word_out", word_out, m_word);
      check("bv_fe_exclusive", 32'(byte_valid & frame_err), 32'h0);
      check("pulse_width", 32'((byte_valid & prev_bv) | (word_valid & prev_wv) | (frame_err & prev_fe)), 32'h0);
      prev_bv = byte_valid; prev_wv = word_valid; prev_fe = frame_err;
      clear_seen = word_clear;
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    if (stop) exp_q.push_back(b);
    rx = 1'b0;
    wait_clk(BIT_CLK);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_clk(BIT_CLK);
    end
    rx = stop;
    wait_clk(BIT_CLK);
    if (stop) begin
      rx = 1'b1;
      wait_clk(16);
    end
  endtask

  task automatic pulse_clear();
    word_clear = 1'b1;
    wait_clk(1);
    word_clear = 1'b0;
    wait_clk(2);
  endtask

  int unsigned bv_save;

  initial begin
    // Reset with rx toggling
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      rx = i[0];
      wait_clk(1);
    end
    check("rst_byte_out", 32'(byte_out), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rx = 1'b1;
    wait_clk(2);
    reset = 1'b1;
    wait_clk(2000);
    check("idle_pulses", bv_cnt + wv_cnt + fe_cnt, 32'd0);
    check("idle_busy", 32'(busy), 32'h0);

    // Single byte
    send_frame(8'hA5, 1'b1);
    check("a5_byte", 32'(byte_out), 32'hA5);
    check("a5_bv_cnt", bv_cnt, 32'd1);
    check("a5_no_word_or_err", wv_cnt + fe_cnt, 32'd0);
    check("a5_busy", 32'(busy), 32'h0);

    // Word assembly from a cleared index
    pulse_clear();
    send_frame(8'h78, 1'b1);
    send_frame(8'h56, 1'b1);
    send_frame(8'h34, 1'b1);
    check("word_not_yet", wv_cnt, 32'd0);
    send_frame(8'h12, 1'b1);
    check("word1", word_out, 32'h12345678);
    check("word1_cnt", wv_cnt, 32'd1);
    check("word1_bv_cnt", bv_cnt, 32'd5);

    // Glitch shorter than half a bit
    rx = 1'b0;
    wait_clk(20);
    rx = 1'b1;
    wait_clk(200);
    check("glitch_bv", bv_cnt, 32'd5);
    check("glitch_fe", fe_cnt, 32'd0);
    check("glitch_busy", 32'(busy), 32'h0);

    // Framing error followed by a held-low line
    send_frame(8'h3C, 1'b0);
    wait_clk(300);
    check("fe_cnt", fe_cnt, 32'd1);
    check("fe_no_byte", bv_cnt, 32'd5);
    check("fe_byte_kept", 32'(byte_out), 32'h12);
    check("fe_busy_break", 32'(busy), 32'h0);
    rx = 1'b1;
    wait_clk(BIT_CLK);
    send_frame(8'h01, 1'b1);
    check("after_fe_byte", 32'(byte_out), 32'h01);
    check("after_fe_cnt", fe_cnt, 32'd1);

    // Partial word discarded by word_clear
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    check("partial_no_word", word_out, 32'h12345678);
    pulse_clear();
    send_frame(8'hDD, 1'b1);
    send_frame(8'hCC, 1'b1);
    send_frame(8'hBB, 1'b1);
    send_frame(8'hAA, 1'b1);
    check("word2", word_out, 32'hAABBCCDD);
    check("word2_cnt", wv_cnt, 32'd2);

    // Reset in the middle of a frame
    bv_save = bv_cnt;
    rx = 1'b0;
    wait_clk(BIT_CLK);
    rx = 1'b1;
    wait_clk(BIT_CLK);
    rx = 1'b0;
    wait_clk(100);
    reset = 1'b0;
    wait_clk(5);
    check("midrst_word", word_out, 32'h0);
    check("midrst_byte", 32'(byte_out), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    rx = 1'b1;
    wait_clk(2);
    reset = 1'b1;
    wait_clk(100);
    check("midrst_no_pulse", bv_cnt, bv_save);
    send_frame(8'h5A, 1'b1);
    check("post_rst_byte", 32'(byte_out), 32'h5A);
    check("post_rst_bv", bv_cnt, bv_save + 1);
    check("exp_queue_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
